// File: rtl/calc_ctrl_pkg.sv
// Shared types and constants for the calculator input controller.
package calc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_OP1    = 2'd0,
        S_OP2    = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } calc_state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;

    localparam int GRID_COLS = 6;
    localparam int GRID_ROWS = 4;

    // Encoding follows the on-screen grid in row-major order, so the
    // linear cell index (row * GRID_COLS + col) is the key code itself.
    typedef enum logic [4:0] {
        K_DIG0 = 5'd0,  K_DIG1 = 5'd1,  K_DIG2 = 5'd2,  K_DIG3 = 5'd3,
        K_DIG4 = 5'd4,  K_DIG5 = 5'd5,  K_DIG6 = 5'd6,  K_DIG7 = 5'd7,
        K_DIG8 = 5'd8,  K_DIG9 = 5'd9,  K_DIGA = 5'd10, K_DIGB = 5'd11,
        K_DIGC = 5'd12, K_DIGD = 5'd13, K_DIGE = 5'd14, K_DIGF = 5'd15,
        K_ADD  = 5'd16, K_SUB  = 5'd17, K_MUL  = 5'd18, K_AND  = 5'd19,
        K_OR   = 5'd20, K_CLR  = 5'd21, K_CE   = 5'd22, K_EXE  = 5'd23
    } calc_key_t;

    function automatic logic key_is_digit(input calc_key_t key);
        return (key <= K_DIGF);
    endfunction

    function automatic logic key_is_op(input calc_key_t key);
        return (key >= K_ADD) && (key <= K_OR);
    endfunction

    function automatic logic [2:0] key_to_op(input calc_key_t key);
        case (key)
            K_ADD:   return OP_ADD;
            K_SUB:   return OP_SUB;
            K_MUL:   return OP_MUL;
            K_AND:   return OP_AND;
            K_OR:    return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_keymap.sv
// Combinational decode of the cursor cell into a key code and digit value.
module calc_keymap
    import calc_ctrl_pkg::*;
(
    input  logic [2:0] pos_x,
    input  logic [1:0] pos_y,
    output calc_key_t  key,
    output logic [3:0] digit
);

    logic [4:0] idx_s;

    // Linear cell index; cells past the last key decode to a harmless EXE.
    always_comb begin
        idx_s = (5'(pos_y) * 5'(GRID_COLS)) + 5'(pos_x);
        digit = idx_s[3:0];
        if (idx_s < 5'(GRID_COLS * GRID_ROWS)) begin
            key = calc_key_t'(idx_s);
        end else begin
            key = K_EXE;
        end
    end

endmodule

// File: rtl/calculator_input_controller.sv
// Cursor, operand accumulator and ALU sequencing for the on-screen calculator.
module calculator_input_controller
    import calc_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_center,
    input  logic        mode,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic [2:0]  pos_x,
    output logic [1:0]  pos_y,
    output logic [2:0]  op,
    output logic [15:0] op1,
    output logic [15:0] op2,
    output logic [15:0] input_screen,
    output logic        alu_start,
    output logic        busy
);

    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
    localparam logic [NDIG_W-1:0] NDIG_MAX  = NDIG_W'(MAX_DIGITS);
    localparam logic [NDIG_W-1:0] NDIG_ZERO = {NDIG_W{1'b0}};
    localparam logic [NDIG_W-1:0] NDIG_ONE  = {{(NDIG_W-1){1'b0}}, 1'b1};

    calc_key_t         key_s;
    logic [3:0]        digit_s;
    calc_state_t       state_r, state_next_s;
    logic [15:0]       entry_r, entry_next_s, entry_base_s, entry_acc_s;
    logic [NDIG_W-1:0] ndig_r, ndig_next_s, ndig_base_s;
    logic [15:0]       res_r, res_next_s;
    logic              mode_r;
    logic [2:0]        pos_x_move_s, op_next_s;
    logic [1:0]        pos_y_move_s;
    logic [15:0]       op1_next_s, op2_next_s, screen_next_s;
    logic              alu_start_next_s;
    logic              press_s, clr_s, digit_ok_s, has_room_s, result_take_s;

    calc_keymap u_keymap (
        .pos_x (pos_x),
        .pos_y (pos_y),
        .key   (key_s),
        .digit (digit_s)
    );

    // Key-press qualification and the candidate accumulator value.
    always_comb begin
        press_s       = btn_center && (state_r != S_WAIT);
        clr_s         = press_s && (key_s == K_CLR);
        digit_ok_s    = key_is_digit(key_s) && (mode || (digit_s < 4'd10));
        // alu_start is high on the first S_WAIT cycle; a done pulse there is stale
        result_take_s = alu_done && !alu_start && (state_r == S_WAIT);
        if (mode != mode_r) begin
            entry_base_s = 16'd0;
            ndig_base_s  = NDIG_ZERO;
        end else begin
            entry_base_s = entry_r;
            ndig_base_s  = ndig_r;
        end
        has_room_s = (ndig_base_s < NDIG_MAX);
        if (mode) begin
            entry_acc_s = {entry_base_s[11:0], digit_s};
        end else begin
            entry_acc_s = (entry_base_s * 16'd10) + {12'd0, digit_s};
        end
    end

    // Cursor movement with wrap; a center press takes the cycle.
    always_comb begin
        pos_x_move_s = pos_x;
        pos_y_move_s = pos_y;
        if (btn_center) begin
            pos_x_move_s = pos_x;
        end else if (btn_up) begin
            pos_y_move_s = (pos_y == 2'd0) ? 2'(GRID_ROWS - 1) : (pos_y - 2'd1);
        end else if (btn_down) begin
            pos_y_move_s = (pos_y == 2'(GRID_ROWS - 1)) ? 2'd0 : (pos_y + 2'd1);
        end else if (btn_left) begin
            pos_x_move_s = (pos_x == 3'd0) ? 3'(GRID_COLS - 1) : (pos_x - 3'd1);
        end else if (btn_right) begin
            pos_x_move_s = (pos_x == 3'(GRID_COLS - 1)) ? 3'd0 : (pos_x + 3'd1);
        end else begin
            pos_y_move_s = pos_y;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_OP1;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_OP1: begin
                if (press_s && key_is_op(key_s)) begin
                    state_next_s = S_OP2;
                end else begin
                    state_next_s = S_OP1;
                end
            end
            S_OP2: begin
                if (clr_s) begin
                    state_next_s = S_OP1;
                end else if (press_s && (key_s == K_EXE)) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_OP2;
                end
            end
            S_WAIT: begin
                if (result_take_s) begin
                    state_next_s = S_RESULT;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESULT: begin
                if (clr_s || (press_s && digit_ok_s)) begin
                    state_next_s = S_OP1;
                end else if (press_s && key_is_op(key_s)) begin
                    state_next_s = S_OP2;
                end else begin
                    state_next_s = S_RESULT;
                end
            end
            default: state_next_s = S_OP1;
        endcase
    end

    // Next values for operands, display, accumulator and ALU start.
    always_comb begin
        op_next_s        = op;
        op1_next_s       = op1;
        op2_next_s       = op2;
        screen_next_s    = input_screen;
        entry_next_s     = entry_base_s;
        ndig_next_s      = ndig_base_s;
        res_next_s       = res_r;
        alu_start_next_s = 1'b0;
        case (state_r)
            S_OP1, S_OP2: begin
                if (press_s && (key_s == K_CE)) begin
                    entry_next_s  = 16'd0;
                    ndig_next_s   = NDIG_ZERO;
                    screen_next_s = 16'd0;
                    if (state_r == S_OP1) begin
                        op1_next_s = 16'd0;
                    end else begin
                        op2_next_s = 16'd0;
                    end
                end else if (press_s && digit_ok_s && has_room_s) begin
                    entry_next_s  = entry_acc_s;
                    ndig_next_s   = ndig_base_s + NDIG_ONE;
                    screen_next_s = entry_acc_s;
                    if (state_r == S_OP1) begin
                        op1_next_s = entry_acc_s;
                    end else begin
                        op2_next_s = entry_acc_s;
                    end
                end else if (press_s && key_is_op(key_s)) begin
                    op_next_s = key_to_op(key_s);
                    if (state_r == S_OP1) begin
                        entry_next_s = 16'd0;
                        ndig_next_s  = NDIG_ZERO;
                    end else begin
                        entry_next_s = entry_base_s;
                    end
                end else if (press_s && (key_s == K_EXE) && (state_r == S_OP2)) begin
                    alu_start_next_s = 1'b1;
                end else begin
                    alu_start_next_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (result_take_s) begin
                    screen_next_s = alu_result;
                    res_next_s    = alu_result;
                end else begin
                    res_next_s = res_r;
                end
            end
            S_RESULT: begin
                if (press_s && (key_s == K_CE)) begin
                    entry_next_s = 16'd0;
                    ndig_next_s  = NDIG_ZERO;
                end else if (press_s && digit_ok_s) begin
                    op_next_s     = OP_ADD;
                    op2_next_s    = 16'd0;
                    res_next_s    = 16'd0;
                    entry_next_s  = {12'd0, digit_s};
                    ndig_next_s   = NDIG_ONE;
                    op1_next_s    = {12'd0, digit_s};
                    screen_next_s = {12'd0, digit_s};
                end else if (press_s && key_is_op(key_s)) begin
                    op1_next_s   = res_r;
                    op2_next_s   = 16'd0;
                    op_next_s    = key_to_op(key_s);
                    entry_next_s = 16'd0;
                    ndig_next_s  = NDIG_ZERO;
                end else begin
                    entry_next_s = entry_base_s;
                end
            end
            default: alu_start_next_s = 1'b0;
        endcase
    end

    // Output and datapath registers; CLR returns everything to reset values.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            pos_x        <= 3'd0;
            pos_y        <= 2'd0;
            op           <= OP_ADD;
            op1          <= 16'd0;
            op2          <= 16'd0;
            input_screen <= 16'd0;
            alu_start    <= 1'b0;
            busy         <= 1'b0;
            entry_r      <= 16'd0;
            ndig_r       <= NDIG_ZERO;
            res_r        <= 16'd0;
            mode_r       <= 1'b0;
        end else if (clr_s) begin
            pos_x        <= 3'd0;
            pos_y        <= 2'd0;
            op           <= OP_ADD;
            op1          <= 16'd0;
            op2          <= 16'd0;
            input_screen <= 16'd0;
            alu_start    <= 1'b0;
            busy         <= 1'b0;
            entry_r      <= 16'd0;
            ndig_r       <= NDIG_ZERO;
            res_r        <= 16'd0;
            mode_r       <= mode;
        end else begin
            pos_x        <= pos_x_move_s;
            pos_y        <= pos_y_move_s;
            op           <= op_next_s;
            op1          <= op1_next_s;
            op2          <= op2_next_s;
            input_screen <= screen_next_s;
            alu_start    <= alu_start_next_s;
            busy         <= (state_next_s == S_WAIT);
            entry_r      <= entry_next_s;
            ndig_r       <= ndig_next_s;
            res_r        <= res_next_s;
            mode_r       <= mode;
        end
    end

endmodule

// File: tb/tb_calculator_input_controller.sv
// Randomized and directed bench for calculator_input_controller against a behavioural model.
module tb_calculator_input_controller;

    logic        clk_vga = 1'b0;
    logic        rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_center;
    logic        mode;
    logic        alu_done;
    logic [15:0] alu_result;
    logic [2:0]  pos_x;
    logic [1:0]  pos_y;
    logic [2:0]  op;
    logic [15:0] op1, op2, input_screen;
    logic        alu_start, busy;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_C    = 5'b10000;
    localparam logic [4:0] B_U    = 5'b01000;
    localparam logic [4:0] B_D    = 5'b00100;
    localparam logic [4:0] B_L    = 5'b00010;
    localparam logic [4:0] B_R    = 5'b00001;

    always #5 clk_vga = ~clk_vga;

    calculator_input_controller #(.MAX_DIGITS(4)) dut (
        .clk_vga      (clk_vga),
        .rst_n        (rst_n),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_center   (btn_center),
        .mode         (mode),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .op           (op),
        .op1          (op1),
        .op2          (op2),
        .input_screen (input_screen),
        .alu_start    (alu_start),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: 0=first operand, 1=second operand, 2=waiting, 3=result
    int          mx, my, ms, m_ndig;
    logic [15:0] m_entry, m_op1, m_op2, m_scr, m_res;
    logic [2:0]  m_op;
    logic        m_start, m_busy, m_mode_prev;

    // ALU responder
    int          alu_cnt = -1;
    logic [15:0] alu_val = 16'd0;
    int          fixed_delay = 5;
    bit          spur_next = 1'b0;
    bit          stray_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        mx = 0; my = 0; ms = 0; m_ndig = 0;
        m_entry = 16'd0; m_op1 = 16'd0; m_op2 = 16'd0; m_scr = 16'd0; m_res = 16'd0;
        m_op = 3'd0; m_start = 1'b0; m_busy = 1'b0;
    endfunction

    function automatic logic [15:0] alu_calc();
        case (m_op)
            3'd0:    return m_op1 + m_op2;
            3'd1:    return m_op1 - m_op2;
            3'd2:    return m_op1 * m_op2;
            3'd3:    return m_op1 & m_op2;
            3'd4:    return m_op1 | m_op2;
            default: return 16'd0;
        endcase
    endfunction

    // One clock of the calculator rules, using the inputs sampled on that edge.
    function automatic void model_step();
        int k, e;
        bit pressed, dig_ok, is_op, started;
        k       = my * 6 + mx;
        pressed = btn_center && (ms != 2);
        started = m_start;
        m_start = 1'b0;
        if (mode != m_mode_prev) begin
            m_entry = 16'd0;
            m_ndig  = 0;
        end
        m_mode_prev = mode;
        if (!btn_center) begin
            if (btn_up)         my = (my + 3) % 4;
            else if (btn_down)  my = (my + 1) % 4;
            else if (btn_left)  mx = (mx + 5) % 6;
            else if (btn_right) mx = (mx + 1) % 6;
        end
        dig_ok = (k < 16) && (mode || (k < 10));
        is_op  = (k >= 16) && (k <= 20);
        if (pressed && k == 21) begin
            model_clear();
        end else if (ms == 0 || ms == 1) begin
            if (pressed && k == 22) begin
                m_entry = 16'd0; m_ndig = 0; m_scr = 16'd0;
                if (ms == 0) m_op1 = 16'd0; else m_op2 = 16'd0;
            end else if (pressed && dig_ok && m_ndig < 4) begin
                if (mode) e = (int'(m_entry) * 16 + k) % 65536;
                else      e = (int'(m_entry) * 10 + k) % 65536;
                m_entry = 16'(e); m_ndig++; m_scr = 16'(e);
                if (ms == 0) m_op1 = 16'(e); else m_op2 = 16'(e);
            end else if (pressed && is_op) begin
                m_op = 3'(k - 16);
                if (ms == 0) begin
                    m_entry = 16'd0; m_ndig = 0; ms = 1;
                end
            end else if (pressed && k == 23 && ms == 1) begin
                m_start = 1'b1; ms = 2;
            end
        end else if (ms == 2) begin
            if (alu_done && !started) begin
                m_scr = alu_result; m_res = alu_result; ms = 3;
            end
        end else if (ms == 3 && pressed) begin
            if (k == 22) begin
                m_entry = 16'd0; m_ndig = 0;
            end else if (dig_ok) begin
                m_op = 3'd0; m_op2 = 16'd0; m_res = 16'd0;
                m_entry = 16'(k); m_ndig = 1; m_op1 = 16'(k); m_scr = 16'(k); ms = 0;
            end else if (is_op) begin
                m_op1 = m_res; m_op2 = 16'd0; m_op = 3'(k - 16);
                m_entry = 16'd0; m_ndig = 0; ms = 1;
            end
        end
        m_busy = (ms == 2);
    endfunction

    task automatic check_all();
        check_eq("pos_x", 32'(pos_x), 32'(mx));
        check_eq("pos_y", 32'(pos_y), 32'(my));
        check_eq("op", 32'(op), 32'(m_op));
        check_eq("op1", 32'(op1), 32'(m_op1));
        check_eq("op2", 32'(op2), 32'(m_op2));
        check_eq("input_screen", 32'(input_screen), 32'(m_scr));
        check_eq("alu_start", 32'(alu_start), 32'(m_start));
        check_eq("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic cycle(input logic [4:0] b);
        {btn_center, btn_up, btn_down, btn_left, btn_right} = b;
        alu_done   = 1'b0;
        alu_result = 16'($urandom);
        if (alu_cnt == 0) begin
            alu_done   = 1'b1;
            alu_result = alu_val;
            alu_cnt    = -1;
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            if (spur_next) alu_done = 1'b1;
        end else if (stray_en && $urandom_range(0, 24) == 0) begin
            alu_done = 1'b1;
        end
        spur_next = 1'b0;
        @(posedge clk_vga);
        model_step();
        if (m_start) begin
            alu_val   = alu_calc();
            alu_cnt   = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6));
            spur_next = stray_en && ($urandom_range(0, 3) == 0);
        end
        #1;
        check_all();
    endtask

    task automatic goto_press(input int k);
        while (my != k / 6) cycle(B_D);
        while (mx != k % 6) cycle(B_R);
        cycle(B_C);
    endtask

    initial begin
        rst_n = 1'b0;
        {btn_center, btn_up, btn_down, btn_left, btn_right} = B_NONE;
        mode = 1'b0; alu_done = 1'b0; alu_result = 16'd0;
        model_clear(); m_mode_prev = 1'b0;
        repeat (3) @(posedge clk_vga);
        #1;
        check_all();
        check_eq("reset_op1", 32'(op1), 32'h0);
        @(negedge clk_vga);
        rst_n = 1'b1;

        // cursor wrap and priority
        cycle(B_L);
        cycle(B_U);
        check_eq("wrap_x", 32'(pos_x), 32'd5);
        check_eq("wrap_y", 32'(pos_y), 32'd3);
        cycle(B_R);
        check_eq("wrap_right", 32'(pos_x), 32'd0);
        cycle(B_U | B_R);
        check_eq("prio_y", 32'(pos_y), 32'd2);
        check_eq("prio_x", 32'(pos_x), 32'd0);

        // decimal entry with ignored hex key and digit limit
        goto_press(1); goto_press(2); goto_press(11);
        goto_press(3); goto_press(4); goto_press(5);
        check_eq("dec_op1", 32'(op1), 32'd1234);
        goto_press(21);

        // hex add through the handshake
        mode = 1'b1;
        cycle(B_NONE);
        goto_press(1); goto_press(10); goto_press(16); goto_press(2);
        goto_press(23);
        check_eq("hex_op1", 32'(op1), 32'h001A);
        check_eq("hex_op", 32'(op), 32'd0);
        check_eq("hex_op2", 32'(op2), 32'h0002);
        check_eq("hex_start", 32'(alu_start), 32'd1);
        check_eq("hex_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 20 && ms != 3; n++) cycle(B_NONE);
        check_eq("hex_result", 32'(input_screen), 32'h001C);
        check_eq("hex_idle", 32'(busy), 32'd0);

        // chaining from the result
        goto_press(18);
        check_eq("chain_op1", 32'(op1), 32'h001C);
        check_eq("chain_op", 32'(op), 32'd2);
        check_eq("chain_op2", 32'(op2), 32'h0000);

        // CE clears only the current operand
        goto_press(5); goto_press(5);
        check_eq("ce_pre_op2", 32'(op2), 32'h0055);
        goto_press(22);
        check_eq("ce_op2", 32'(op2), 32'h0000);
        check_eq("ce_op1", 32'(op1), 32'h001C);
        check_eq("ce_op", 32'(op), 32'd2);

        // CLR is ignored while waiting, honoured in the result state
        fixed_delay = 20;
        goto_press(23);
        goto_press(21);
        check_eq("wait_clr_busy", 32'(busy), 32'd1);
        check_eq("wait_clr_op1", 32'(op1), 32'h001C);
        for (int n = 0; n < 40 && ms != 3; n++) cycle(B_NONE);
        check_eq("wait_done", 32'(busy), 32'd0);
        goto_press(21);
        check_eq("clr_pos", 32'({pos_y, pos_x}), 32'd0);
        check_eq("clr_op1", 32'(op1), 32'd0);
        check_eq("clr_screen", 32'(input_screen), 32'd0);

        // asynchronous reset in the middle of an operation
        fixed_delay = 30;
        goto_press(3); goto_press(16); goto_press(4); goto_press(23);
        cycle(B_NONE);
        @(negedge clk_vga);
        rst_n = 1'b0;
        #1;
        model_clear(); m_mode_prev = 1'b0; alu_cnt = -1; spur_next = 1'b0;
        check_all();
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_op1", 32'(op1), 32'd0);
        @(negedge clk_vga);
        rst_n = 1'b1;
        alu_val = 16'hBEEF;
        alu_cnt = 1;
        repeat (3) cycle(B_NONE);
        check_eq("late_done_screen", 32'(input_screen), 32'd0);
        check_eq("late_done_start", 32'(alu_start), 32'd0);

        // randomized traffic
        fixed_delay = 0;
        stray_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                if ($urandom_range(0, 29) == 0) mode = ~mode;
                cycle(B_NONE);
            end else if (r < 65) begin
                cycle(B_C);
            end else if (r < 90) begin
                case ($urandom_range(0, 3))
                    0:       cycle(B_U);
                    1:       cycle(B_D);
                    2:       cycle(B_L);
                    default: cycle(B_R);
                endcase
            end else begin
                cycle(5'($urandom_range(0, 31)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
